fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the single-cycle RISC-V core, upstream of decode and the immediate generator. It holds the PC and issues in-order word requests to instruction memory over a valid/ready handshake. Returned words are buffered in a small prefetch FIFO and presented to decode with their PC and the 25-bit immediate source field (instr[31:7]). Branch/jump redirects flush the FIFO and discard stale in-flight responses.

## Interface
- DWIDTH, 32, instruction/address width
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2); also the maximum in-flight plus buffered instructions
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  request present
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  DWIDTH  word-aligned fetch address
- imem_resp_valid  in  1  response word present (in order, ≥1 cycle after accept, never back-pressured)
- imem_resp_data  in  DWIDTH  instruction word
- redirect_valid  in  1  control-flow change
- redirect_pc  in  DWIDTH  new PC
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode consumes head
- inst_out  out  DWIDTH  head instruction
- inst_pc  out  DWIDTH  PC of head instruction
- imm_field  out  25  inst_out[31:7], feeds immediate generator

## Operation
- State: pc, FIFO (data+PC per entry), count, outstanding counter, drop counter; counter widths $clog2(DEPTH)+1.
- Request: imem_req_valid = state RUN && (outstanding + count) < DEPTH; imem_req_addr = pc. On accept: pc += 4 (wraps mod 2^32), outstanding += 1, PC tag pushed to an in-flight tag queue.
- Response: outstanding -= 1. If drop > 0: discard, drop -= 1. Else push {data, tag} into FIFO.
- Pop on inst_valid && inst_ready.
- Redirect (highest priority): pc ← redirect_pc with [1:0] cleared; FIFO and tag queue cleared; drop ← outstanding after this cycle (includes a request accepted this cycle, excludes a response this cycle); a response arriving this cycle is discarded; a pop this cycle is honoured.
- States: RUN, HALT. RUN→HALT only under FETCH_MISALIGN_EN. HALT→RUN on aligned redirect.
- Credit rule guarantees no FIFO overflow; push and pop in the same cycle at full or empty is legal.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst_out 0, inst_pc 0, imm_field 0, counters 0, state RUN.
- First request in the first cycle after rst deasserts.
- Response at cycle N → inst_valid at N+1 (registered FIFO); FIFO is not bypassed.
- Redirect at cycle N → imem_req_addr = new PC at N+1; inst_valid 0 at N+1.
- Redirect while rst is asserted is ignored. Reset mid-operation clears all state; responses to pre-reset requests must not be delivered by memory.

## Configuration
- FETCH_MISALIGN_EN defined: adds output fetch_misalign (1 bit, reset 0). A redirect with redirect_pc[1:0] ≠ 0 sets fetch_misalign, applies the normal flush, and enters HALT (no requests). The next aligned redirect clears fetch_misalign and returns to RUN.
- Undefined: no port; low bits are silently cleared and the state stays RUN.

## Test plan
- Reset release, memory always ready, 1-cycle latency, inst_ready=1 → addresses 0,4,8,…; inst_pc matches; one instruction per cycle after 2-cycle fill.
- inst_ready=0 → exactly DEPTH (4) requests issued, then imem_req_valid=0 until a pop.
- Redirect to 0x100 with 3 responses in flight → those 3 dropped; next inst_pc = 0x100.
- Redirect coinciding with a response and a pop → response discarded, popped entry delivered once, no duplicate.
- Response word 0xFE000EE3 → imm_field = 0x1FC001D.
- FETCH_MISALIGN_EN: redirect 0x102 → fetch_misalign=1, no requests; redirect 0x200 → flag cleared, fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, and a prefetch FIFO feeding decode.
// Optional FETCH_MISALIGN_EN adds a fetch_misalign flag and a HALT state for misaligned redirect targets.
module fetch_unit #(
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DWIDTH-1:0] imem_resp_data,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst_out,
  output logic [DWIDTH-1:0] inst_pc,
  output logic [24:0]       imm_field
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              fetch_misalign
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t            state;
  logic [DWIDTH-1:0] pc;
  logic [DWIDTH-1:0] fifo_data [DEPTH];
  logic [DWIDTH-1:0] fifo_pc   [DEPTH];
  logic [DWIDTH-1:0] tag_q     [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0]     count, outstanding, drop, out_next;
  logic              req_fire, pop, push;

  // Credit check: in-flight plus buffered words never exceed the FIFO size.
  assign imem_req_valid = !rst && (state == RUN) &&
                          (({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign inst_valid     = (count != '0);
  assign inst_out       = fifo_data[rd_ptr];
  assign inst_pc        = fifo_pc[rd_ptr];
  assign imm_field      = inst_out[31:7];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pop      = inst_valid && inst_ready;
  assign push     = imem_resp_valid && (drop == '0) && !redirect_valid;
  assign out_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
        tag_q[i]     <= '0;
      end
`ifdef FETCH_MISALIGN_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path and must be dropped.
        pc     <= redirect_pc & ~DWIDTH'(3);
        rd_ptr <= '0;
        wr_ptr <= '0;
        tag_rd <= '0;
        tag_wr <= '0;
        count  <= '0;
        drop   <= out_next;
`ifdef FETCH_MISALIGN_EN
        if (redirect_pc[1:0] != 2'b00) begin
          state          <= HALT;
          fetch_misalign <= 1'b1;
        end else begin
          state          <= RUN;
          fetch_misalign <= 1'b0;
        end
`else
        state <= RUN;
`endif
      end else begin
        if (req_fire) begin
          pc            <= pc + DWIDTH'(4);
          tag_q[tag_wr] <= pc;
          tag_wr        <= tag_wr + PW'(1);
        end
        if (imem_resp_valid && (drop != '0))
          drop <= drop - CW'(1);
        if (push) begin
          fifo_data[wr_ptr] <= imem_resp_data;
          fifo_pc[wr_ptr]   <= tag_q[tag_rd];
          wr_ptr            <= wr_ptr + PW'(1);
          tag_rd            <= tag_rd + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
